// File: rtl/bht_update_scheduler_pkg.sv
// Shared BHT update constants and entry packing, reused by the BHT and execute.
package bht_update_scheduler_pkg;
  localparam int BHT_IDX_W     = 8;
  localparam int BHT_UPD_DEPTH = 4;

  // Queue entry layout: {idx, dir}, dir in the LSB.
  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic                 dir;
  } bht_upd_t;

  localparam int BHT_UPD_W = $bits(bht_upd_t);
endpackage

// File: rtl/bht_update_scheduler_if.sv
// Execute-side update bus plus BHT write port of the update scheduler.
interface bht_update_scheduler_if
  import bht_update_scheduler_pkg::*;
#(
  parameter int IDX_W = BHT_IDX_W,
  parameter int DEPTH = BHT_UPD_DEPTH
) ();
  logic                     stall;
  logic                     upd0_valid;
  logic [IDX_W-1:0]         upd0_idx;
  logic                     upd0_dir;
  logic                     upd1_valid;
  logic [IDX_W-1:0]         upd1_idx;
  logic                     upd1_dir;
  logic                     upd_ready;
  logic                     bht_we;
  logic [IDX_W-1:0]         bht_widx;
  logic                     bht_wdir;
  logic [$clog2(DEPTH):0]   q_count;
  logic                     ovf_err;

  modport slave (
    input  stall, upd0_valid, upd0_idx, upd0_dir, upd1_valid, upd1_idx, upd1_dir,
    output upd_ready, bht_we, bht_widx, bht_wdir, q_count, ovf_err
  );

  modport master (
    output stall, upd0_valid, upd0_idx, upd0_dir, upd1_valid, upd1_idx, upd1_dir,
    input  upd_ready, bht_we, bht_widx, bht_wdir, q_count, ovf_err
  );
endinterface

// File: rtl/bht_upd_fifo.sv
// 2-write/1-read circular buffer with occupancy count; caller guarantees no overflow/underflow.
module bht_upd_fifo
  import bht_update_scheduler_pkg::*;
#(
  parameter int  DEPTH = BHT_UPD_DEPTH,
  parameter int  W     = BHT_UPD_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [1:0]       wr_cnt,
  input  logic [W-1:0]     wr_data0,
  input  logic [W-1:0]     wr_data1,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, tail_nxt;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    tail_nxt = tail_q + PTR_W'(1);
    if (wr_cnt != 2'd0) mem_d[tail_q]   = wr_data0;
    if (wr_cnt == 2'd2) mem_d[tail_nxt] = wr_data1;
    tail_d  = tail_q + PTR_W'(wr_cnt);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(wr_cnt) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[head_q];
  assign count   = count_q;
endmodule

// File: rtl/bht_update_scheduler.sv
// Funnels up to two branch updates per cycle into the single BHT write port.
// Optional same-cycle bypass of an empty queue: define BHT_UPD_BYPASS_EN.
module bht_update_scheduler
  import bht_update_scheduler_pkg::*;
#(
  parameter int DEPTH = BHT_UPD_DEPTH,
  parameter int IDX_W = BHT_IDX_W
) (
  input logic                    clk,
  input logic                    resetn,
  bht_update_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int W     = IDX_W + 1;

  logic [CNT_W-1:0] count;
  logic [W-1:0]     head, e0, e1, first_e, wr0, drive;
  logic [1:0]       wr_cnt, n_valid;
  logic             any_valid, ready, pop, byp;
  logic             ovf_err_q, ovf_err_d;

  always_comb begin
    e0        = {bus.upd0_idx, bus.upd0_dir};
    e1        = {bus.upd1_idx, bus.upd1_dir};
    any_valid = bus.upd0_valid | bus.upd1_valid;
    n_valid   = {1'b0, bus.upd0_valid} + {1'b0, bus.upd1_valid};
    first_e   = bus.upd0_valid ? e0 : e1;
    ready     = count <= CNT_W'(DEPTH - 2);
    pop       = (count != '0) && !bus.stall;
`ifdef BHT_UPD_BYPASS_EN
    byp       = (count == '0) && !bus.stall && ready && any_valid;
`else
    byp       = 1'b0;
`endif
    // A bypassed oldest update leaves only slot 1 (if any) for the queue.
    wr_cnt = 2'd0;
    wr0    = first_e;
    if (ready) begin
      wr_cnt = n_valid - {1'b0, byp};
      if (byp) wr0 = e1;
    end
    ovf_err_d = ovf_err_q | (any_valid && !ready);
  end

  always_ff @(posedge clk) begin
    if (resetn) ovf_err_q <= 1'b0;
    else        ovf_err_q <= ovf_err_d;
  end

  bht_upd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk      (clk),
    .srst     (resetn),
    .wr_cnt   (wr_cnt),
    .wr_data0 (wr0),
    .wr_data1 (e1),
    .pop      (pop),
    .rd_data  (head),
    .count    (count)
  );

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    drive = '0;
    if (!resetn) begin
      if (pop)      drive = head;
      else if (byp) drive = first_e;
    end
    bus.bht_we    = !resetn && (pop || byp);
    bus.bht_widx  = drive[W-1:1];
    bus.bht_wdir  = drive[0];
    bus.upd_ready = resetn || ready;
    bus.q_count   = resetn ? '0 : count;
    bus.ovf_err   = !resetn && ovf_err_q;
  end
endmodule

// File: doc/bht_update_scheduler.md
# bht_update_scheduler

Sequences branch-resolution updates into the branch history table's single write port. Accepts up to two resolved-branch updates per cycle from the dual-issue execute stage, buffers them in a small in-order queue and drains one update per cycle to the BHT write port, honouring the pipeline stall. It sits between the execute/branch-resolution logic and `branch_history_table`, and asserts backpressure toward execute when the queue cannot take a full pair.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `IDX_W`, 8: BHT index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-high reset (asserted = 1).
- `stall`  in  1  pipeline stall; blocks draining only.
- `upd0_valid`  in  1  slot-0 update present; slot 0 is the older instruction.
- `upd0_idx`  in  IDX_W  slot-0 BHT index.
- `upd0_dir`  in  1  slot-0 resolved direction (1 = taken).
- `upd1_valid`, `upd1_idx`, `upd1_dir`  in  1/IDX_W/1  slot-1 update, same meaning.
- `upd_ready`  out  1  queue can accept two updates this cycle.
- `bht_we`  out  1  BHT write enable.
- `bht_widx`  out  IDX_W  BHT index to shift.
- `bht_wdir`  out  1  direction bit shifted into the BHR LSB.
- `q_count`  out  clog2(DEPTH)+1  current occupancy.
- `ovf_err`  out  1  sticky; an update arrived while `upd_ready` = 0.

## Operation
- Queue is in order. When both slots are valid, slot 0 is enqueued ahead of slot 1. A lone slot-1 update is enqueued like a single push.
- `upd_ready` = (DEPTH − q_count) ≥ 2. It is combinational from registered count.
- Push: at the edge, if `upd_ready`, each valid slot writes at tail/tail+1. Tail advances by the number of valid slots.
- Drop: valid slots arriving with `upd_ready` = 0 are discarded, not partially accepted, and `ovf_err` is set to 1. `ovf_err` is cleared only by reset.
- Drain: `bht_we` = (q_count ≠ 0) && !`stall`. `bht_widx`/`bht_wdir` show the head entry. The head pops at the edge where `bht_we` = 1.
- Count arithmetic: next count = count + pushes − pop. Push and pop in the same cycle are legal, including at count = DEPTH−2 with a two-slot push and a pop.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided from `q_count` only.
- While `stall` = 1, pushes are still accepted. The queue only grows, and `bht_we` = 0.
- Reset clears pointers, count and `ovf_err` in the same edge, discarding queued updates. Outputs during reset: `bht_we` = 0, `bht_widx` = 0, `bht_wdir` = 0, `q_count` = 0, `ovf_err` = 0, `upd_ready` = 1 (valid because DEPTH ≥ 2).
- When `bht_we` = 0, `bht_widx`/`bht_wdir` are driven 0.

## Timing
- Without bypass:
  - An update accepted at edge N with an empty queue appears on the write port in cycle N+1.
  - It is written into the BHT at edge N+1.
- Throughput: one BHT write per unstalled cycle.
- Order: two updates to the same index are written in acceptance order, on consecutive cycles minimum.
- `upd_ready` reflects state after the previous edge. Execute must treat `upd_ready` = 0 as a stall request.

## Configuration
- `BHT_UPD_BYPASS_EN` defined:
  - Applies when q_count = 0, `stall` = 0, `upd_ready` = 1 and at least one slot is valid.
  - The oldest valid incoming update drives `bht_we`/`bht_widx`/`bht_wdir` combinationally in the same cycle and is not enqueued.
  - The remaining update, if any, is enqueued.
  - Latency is 0 cycles (written at edge N).
- Not defined: no combinational path from `upd*` to `bht_*`, and latency is 1 cycle.

## Structure
- Shared package/defines:
  - `BHT_IDX_W` (8).
  - `BHT_UPD_DEPTH` (4).
  - Update-entry packing {idx, dir} and its width constant.
  - These are reused by `branch_history_table` and execute.
- Sub-module `bht_upd_fifo`: 2-write/1-read circular buffer with count. The scheduler wraps it with the ready, drain, bypass and error logic.

## Test plan
- Reset, then slot0 {idx 0x12, dir 1} for one cycle → `bht_we` = 1 with idx 0x12, dir 1 in the next cycle (same cycle with bypass); `q_count` returns to 0.
- Both slots valid {0x05, 1} and {0x05, 0} → writes 0x05/1 then 0x05/0 on consecutive cycles, in that order.
- `stall` = 1 while pushing pairs for 2 cycles (DEPTH = 4) → `q_count` = 4, `upd_ready` = 0, `bht_we` = 0. A third pair is dropped and `ovf_err` = 1. Releasing stall → 4 writes in order.
- q_count = 2 with stall low; push pair and pop in the same cycle → `q_count` = 3, and the entries wrap correctly past index DEPTH−1.
- Lone slot-1 update {0x7F, 1} → written exactly once with idx 0x7F, dir 1.
- `resetn` = 1 with 3 entries queued → next cycle `q_count` = 0, `bht_we` = 0, `ovf_err` = 0, and no stale writes afterward.
